cpu8_core: RTL and testbench



---
 rtl/cpu8_pkg.sv | 34 +++
 rtl/cpu8_if.sv | 23 ++
 rtl/cpu8_alu.sv | 26 ++
 rtl/cpu8_core.sv | 125 ++++++++++++
 tb/tb_cpu8_core.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/cpu8_pkg.sv
// Shared opcode, ALU-op, state and instruction-field definitions for the cpu8 core.
package cpu8_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_HLT  = 4'b1100;
  localparam logic [3:0] OP_JNZ  = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/cpu8_if.sv
// Program-load, run control, debug-read and status bundle between the core and its host.
interface cpu8_if;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        run;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [7:0]  alu_out;
  logic        halted;

  modport master (
    output prog_we, prog_addr, prog_data, run, dbg_sel,
    input  dbg_data, pc, ir, alu_out, halted
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, dbg_sel,
    output dbg_data, pc, ir, alu_out, halted
  );
endinterface

// File: rtl/cpu8_alu.sv
// Combinational 8-bit ALU, modulo-256 arithmetic, no flags.
module cpu8_alu
  import cpu8_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      ALU_NOT: o_y = ~i_a;
      ALU_SHL: o_y = {i_a[6:0], 1'b0};
      ALU_SHR: o_y = {1'b0, i_a[7:1]};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/cpu8_core.sv
// 8-bit two-cycle fetch/execute core: 256x16 imem, 4x8 register file, ALU, sequencer.
module cpu8_core
  import cpu8_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  cpu8_if.slave  bus
);

  logic [15:0] r_imem [256];
  logic [7:0]  r_regs [4];
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic        r_halted;
  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  w_op;
  logic [1:0]  w_rd, w_rs1, w_rs2;
  logic [7:0]  w_imm;
  logic [2:0]  w_alu_op;
  logic [7:0]  w_alu_a, w_alu_b, w_alu_y;
  logic        w_reg_we, w_ir_ld, w_halt_set;
  logic [7:0]  w_reg_wdat, w_pc_nxt;

  assign w_op  = r_ir[OP_LSB +: 4];
  assign w_rd  = r_ir[RD_LSB +: 2];
  assign w_rs1 = r_ir[RS1_LSB +: 2];
  assign w_rs2 = r_ir[RS2_LSB +: 2];
  assign w_imm = r_ir[IMM_LSB +: 8];

  // INC/DEC reuse the add/sub datapath with R[rd] and a constant one.
  always_comb begin
    w_alu_op = ALU_ADD;
    w_alu_a  = r_regs[w_rs1];
    w_alu_b  = r_regs[w_rs2];
    case (w_op)
      OP_SUB: w_alu_op = ALU_SUB;
      OP_INC: begin
        w_alu_a = r_regs[w_rd];
        w_alu_b = 8'h01;
      end
      OP_DEC: begin
        w_alu_op = ALU_SUB;
        w_alu_a  = r_regs[w_rd];
        w_alu_b  = 8'h01;
      end
      default: ;
    endcase
  end

  cpu8_alu u_alu (
    .i_op (w_alu_op),
    .i_a  (w_alu_a),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ir_ld     = 1'b0;
    w_reg_we    = 1'b0;
    w_reg_wdat  = w_alu_y;
    w_pc_nxt    = r_pc;
    w_halt_set  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ir_ld = 1'b1;
        if (bus.run) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = r_pc + 8'd1;
        case (w_op)
          OP_ADD, OP_SUB, OP_INC, OP_DEC: w_reg_we = 1'b1;
          OP_LOAD: begin
            w_reg_we   = 1'b1;
            w_reg_wdat = w_imm;
          end
          OP_JMP: w_pc_nxt = w_imm;
          OP_JNZ: if (r_regs[w_rd] != 8'd0) w_pc_nxt = w_imm;
          OP_HLT: begin
            w_pc_nxt    = r_pc;
            w_halt_set  = 1'b1;
            w_state_nxt = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_HALT: ;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ir_ld)    r_ir <= r_imem[r_pc];
      if (w_reg_we)   r_regs[w_rd] <= w_reg_wdat;
      if (w_halt_set) r_halted <= 1'b1;
    end
  end

  // Program memory is outside the reset domain so a host can load it while the core is held.
  always_ff @(posedge i_clk) begin
    if (bus.prog_we) r_imem[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.dbg_data = r_regs[bus.dbg_sel];
  assign bus.pc       = r_pc;
  assign bus.ir       = r_ir;
  assign bus.alu_out  = w_alu_y;
  assign bus.halted   = r_halted;

endmodule

// File: tb/tb_cpu8_core.sv
// Directed self-checking bench for cpu8_core plus a standalone cpu8_alu vector sweep.
module tb_cpu8_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu8_if bus();

  cpu8_core dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;

  cpu8_alu u_alu (
    .i_op (alu_op),
    .i_a  (alu_a),
    .i_b  (alu_b),
    .o_y  (alu_y)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick(1);
    bus.prog_we   = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    bus.dbg_sel = sel;
    #1;
    check(tag, {8'h00, bus.dbg_data}, {8'h00, exp});
  endtask

  task automatic run_until_halt(input string tag, input int exp_cycles);
    int cyc;
    cyc = 0;
    bus.run = 1'b1;
    while (!bus.halted && cyc < 300) begin
      tick(1);
      cyc++;
    end
    check({tag, "_cycles"}, 16'(cyc), 16'(exp_cycles));
  endtask

  logic [7:0] alu_exp [8];

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.run       = 1'b0;
    bus.dbg_sel   = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_op        = '0;

    // Program 1: add/sub, loaded while reset is held.
    rst = 1'b1;
    tick(2);
    load(8'd0, 16'h8005);
    load(8'd1, 16'h8103);
    load(8'd2, 16'h0201);
    load(8'd3, 16'h1301);
    load(8'd4, 16'hC000);
    rst = 1'b0;
    check("rst_pc", {8'h00, bus.pc}, 16'h0000);
    check("rst_ir", bus.ir, 16'h0000);
    check("rst_alu", {8'h00, bus.alu_out}, 16'h0000);
    check("rst_halted", {15'h0, bus.halted}, 16'h0000);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);

    run_until_halt("p1", 10);
    check("p1_halted", {15'h0, bus.halted}, 16'h0001);
    check("p1_pc", {8'h00, bus.pc}, 16'h0004);
    check_reg("p1_r2", 2'd2, 8'd8);
    check_reg("p1_r3", 2'd3, 8'd2);
    tick(5);
    check("p1_pc_frozen", {8'h00, bus.pc}, 16'h0004);

    // Program 2: INC/DEC wrap.
    rst = 1'b1;
    bus.run = 1'b0;
    load(8'd0, 16'h80FF);
    load(8'd1, 16'hA000);
    load(8'd2, 16'h8100);
    load(8'd3, 16'hB100);
    load(8'd4, 16'hC000);
    rst = 1'b0;
    run_until_halt("p2", 10);
    check_reg("p2_r0_wrap", 2'd0, 8'h00);
    check_reg("p2_r1_wrap", 2'd1, 8'hFF);

    // Program 3: DEC/JNZ loop, three iterations.
    rst = 1'b1;
    bus.run = 1'b0;
    load(8'd0, 16'h8003);
    load(8'd1, 16'hB000);
    load(8'd2, 16'hE001);
    load(8'd3, 16'hC000);
    rst = 1'b0;
    run_until_halt("p3", 16);
    check("p3_pc", {8'h00, bus.pc}, 16'h0003);
    check_reg("p3_r0", 2'd0, 8'h00);

    // Program 4: JMP over a LOAD.
    rst = 1'b1;
    bus.run = 1'b0;
    load(8'd0, 16'hF00A);
    load(8'd1, 16'h8007);
    load(8'd10, 16'hC000);
    rst = 1'b0;
    run_until_halt("p4", 4);
    check("p4_pc", {8'h00, bus.pc}, 16'h000A);
    check_reg("p4_r0", 2'd0, 8'h00);

    // Reset during EXEC of an ADD, then hold with run low.
    rst = 1'b1;
    bus.run = 1'b0;
    load(8'd0, 16'h8005);
    load(8'd1, 16'h8103);
    load(8'd2, 16'h0201);
    load(8'd3, 16'hC000);
    rst = 1'b0;
    bus.run = 1'b1;
    tick(5);
    check("mid_ir", bus.ir, 16'h0201);
    check("mid_alu", {8'h00, bus.alu_out}, 16'h0008);
    check("mid_pc", {8'h00, bus.pc}, 16'h0002);
    rst = 1'b1;
    tick(1);
    check("abort_pc", {8'h00, bus.pc}, 16'h0000);
    check_reg("abort_r2", 2'd2, 8'h00);
    rst = 1'b0;
    bus.run = 1'b0;
    tick(10);
    check("idle_pc", {8'h00, bus.pc}, 16'h0000);
    check("idle_halted", {15'h0, bus.halted}, 16'h0000);

    // ALU sweep with A=200, B=100.
    alu_exp = '{8'd44, 8'd100, 8'd64, 8'd236, 8'd172, 8'd55, 8'd144, 8'd100};
    alu_a = 8'd200;
    alu_b = 8'd100;
    for (int op = 0; op < 8; op++) begin
      alu_op = 3'(op);
      #1;
      check("alu", {8'h00, alu_y}, {8'h00, alu_exp[op]});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
